// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-cycle sequencer: state encodings,
// micro-step code types and the end-of-instruction rule.
package cpu_pkg;

  localparam int CODE_W = 4;
  typedef logic [CODE_W-1:0] code_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_ADVANCE = 3'd3;
  localparam logic [2:0] ST_STEP    = 3'd4;
  localparam logic [2:0] ST_FAULT   = 3'd5;

  typedef enum logic [CODE_W-1:0] {
    LD_NONE      = 4'h0,
    LD_ESP       = 4'h1,
    LD_EBP_EBX   = 4'h2,
    LD_EAX       = 4'h3,
    LD_EIP       = 4'h4,
    LD_STACK_ACC = 4'h5,
    LD_EDI       = 4'h6
  } load_code_e;

  typedef enum logic [CODE_W-1:0] {
    SEL_NONE  = 4'h0,
    SEL_ESP   = 4'h1,
    SEL_EBP   = 4'h2,
    SEL_EAX   = 4'h3,
    SEL_EIP   = 4'h4,
    SEL_STACK = 4'h5,
    SEL_EDI   = 4'h6,
    SEL_IMM   = 4'h7
  } select_code_e;

  // An instruction ends after its third step or when the following slot is unused.
  function automatic logic is_last_step(input logic [1:0] idx, input code_t next_load);
    return (idx == 2'd2) || (next_load == LD_NONE);
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Bundle between the sequencer, the fetch unit, decode and the register/ALU datapath.
interface exec_sequencer_if
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             start;
  logic             halt_req;
  logic             fetch_req;
  logic             fetch_ack;
  logic             ope_latch;
  code_t            reg_load_1, reg_load_2, reg_load_3;
  code_t            select_1, select_2, select_3;
  logic [3:0]       num_of_ope;
  logic             mem_wait;
  code_t            alu_load;
  code_t            alu_select;
  logic             step_en;
  logic [1:0]       step_idx;
  logic             eip_add_en;
  logic [3:0]       eip_add;
  logic             busy;
  logic             fault;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  start, halt_req, fetch_ack, reg_load_1, reg_load_2, reg_load_3,
           select_1, select_2, select_3, num_of_ope, mem_wait,
    output fetch_req, ope_latch, alu_load, alu_select, step_en, step_idx,
           eip_add_en, eip_add, busy, fault, instr_count
  );

  modport slave (
    output start, halt_req, fetch_ack, reg_load_1, reg_load_2, reg_load_3,
           select_1, select_2, select_3, num_of_ope, mem_wait,
    input  fetch_req, ope_latch, alu_load, alu_select, step_en, step_idx,
           eip_add_en, eip_add, busy, fault, instr_count
  );

endinterface

// File: rtl/seq_watchdog.sv
// Saturating wait counter; expired flags the cycle on which the count would reach MAX_WAIT.
module seq_watchdog #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk2,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(MAX_WAIT + 1);

  logic [W-1:0] count_q;

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk2) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable && (count_q != W'(MAX_WAIT))) begin
      count_q <= count_q + W'(1);
    end
  end

  // Looks one cycle ahead so the owner leaves its state on exactly the MAX_WAIT-th wait.
  assign expired = enable && (count_q == W'(MAX_WAIT - 1));

endmodule

// File: rtl/exec_sequencer.sv
// Instruction-cycle FSM: fetch, decode settle, eip advance, then up to three
// (load, select) micro-steps; also owns the retired-instruction counter.
module exec_sequencer
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk2,
  input  logic             reset,
  exec_sequencer_if.master bus
);

  logic [2:0]       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] count_q;
  code_t            cur_load, cur_sel, next_load;
  logic             adv_ok, adv_pulse, in_step, commit, retire;
  logic             wd_enable, wd_clear, wd_expired;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    cur_load  = bus.reg_load_1;
    cur_sel   = bus.select_1;
    next_load = bus.reg_load_2;
    case (idx_q)
      2'd1: begin
        cur_load  = bus.reg_load_2;
        cur_sel   = bus.select_2;
        next_load = bus.reg_load_3;
      end
      2'd2: begin
        cur_load  = bus.reg_load_3;
        cur_sel   = bus.select_3;
        next_load = LD_NONE;
      end
      default: ;
    endcase
  end

  assign adv_ok    = (bus.num_of_ope != 4'h0) && (bus.reg_load_1 != LD_NONE);
  assign in_step   = (state_q == ST_STEP);
  assign commit    = in_step && !bus.mem_wait;
  assign retire    = commit && is_last_step(idx_q, next_load);
  assign wd_enable = ((state_q == ST_FETCH) && !bus.fetch_ack) || (in_step && bus.mem_wait);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE:    if (bus.start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.fetch_ack)  state_d = ST_DECODE;
        else if (wd_expired) state_d = ST_FAULT;
      end
      ST_DECODE:  state_d = ST_ADVANCE;
      ST_ADVANCE: begin
        state_d = adv_ok ? ST_STEP : ST_FAULT;
        idx_d   = 2'd0;
      end
      ST_STEP: begin
        if (bus.mem_wait) begin
          if (wd_expired) state_d = ST_FAULT;
        end else if (retire) begin
          state_d = bus.halt_req ? ST_IDLE : ST_FETCH;
          idx_d   = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      ST_FAULT:   ;
      default:    state_d = ST_FAULT;
    endcase
  end

  assign wd_clear = (state_d != state_q) || commit;

  seq_watchdog #(.MAX_WAIT(MAX_WAIT)) u_watchdog (
    .clk2    (clk2),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk2) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  // eip moves in ADVANCE, ahead of any step that reads or reloads it.
  assign adv_pulse       = (state_q == ST_ADVANCE) && adv_ok;
  assign bus.eip_add_en  = adv_pulse;
  assign bus.eip_add     = adv_pulse ? bus.num_of_ope : 4'h0;
  assign bus.fetch_req   = (state_q == ST_FETCH);
  assign bus.ope_latch   = (state_q == ST_FETCH) && bus.fetch_ack;
  assign bus.step_en     = in_step;
  assign bus.step_idx    = in_step ? idx_q : 2'd0;
  assign bus.alu_load    = in_step ? cur_load : LD_NONE;
  assign bus.alu_select  = in_step ? cur_sel : 4'h0;
  assign bus.busy        = (state_q != ST_IDLE) && (state_q != ST_FAULT);
  assign bus.fault       = (state_q == ST_FAULT);
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomised bench: a trace model built from the instruction-cycle rules predicts every output each cycle.
module tb_exec_sequencer;
  import cpu_pkg::*;

  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 6;

  logic clk2  = 1'b0;
  logic reset = 1'b1;

  exec_sequencer_if #(.CNT_W(CNT_W)) bus ();

  exec_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk2  (clk2),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk2 = ~clk2;

  typedef struct packed {
    logic             fetch_req;
    logic             ope_latch;
    logic             step_en;
    logic [1:0]       step_idx;
    logic [3:0]       alu_load;
    logic [3:0]       alu_select;
    logic             eip_add_en;
    logic [3:0]       eip_add;
    logic             busy;
    logic             fault;
    logic [CNT_W-1:0] instr_count;
  } obs_t;

  typedef struct {
    code_t      ld [3];
    code_t      sel [3];
    logic [3:0] len;
    int         ack_delay;
    int         waits [3];
    bit         halt;
    bit         hold_halt;
    int         abort_step;
  } instr_t;

  typedef enum {R_FETCH, R_IDLE, R_FAULT} end_e;

  int               vectors     = 0;
  int               miscompares = 0;
  logic [CNT_W-1:0] model_count = '0;

  function automatic obs_t observe();
    obs_t o;
    o.fetch_req   = bus.fetch_req;
    o.ope_latch   = bus.ope_latch;
    o.step_en     = bus.step_en;
    o.step_idx    = bus.step_idx;
    o.alu_load    = bus.alu_load;
    o.alu_select  = bus.alu_select;
    o.eip_add_en  = bus.eip_add_en;
    o.eip_add     = bus.eip_add;
    o.busy        = bus.busy;
    o.fault       = bus.fault;
    o.instr_count = bus.instr_count;
    return o;
  endfunction

  function automatic obs_t quiet();
    obs_t o = '0;
    o.instr_count = model_count;
    return o;
  endfunction

  function automatic obs_t busy_only();
    obs_t o = quiet();
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic instr_t mk(code_t l0, code_t l1, code_t l2, logic [3:0] len);
    instr_t r;
    r.ld[0] = l0; r.ld[1] = l1; r.ld[2] = l2;
    for (int i = 0; i < 3; i++) begin
      r.sel[i]   = 4'($urandom_range(0, 15));
      r.waits[i] = 0;
    end
    r.len        = len;
    r.ack_delay  = 0;
    r.halt       = 1'b0;
    r.hold_halt  = 1'b0;
    r.abort_step = -1;
    return r;
  endfunction

  task automatic scramble();
    bus.start     = 1'($urandom);
    bus.halt_req  = 1'($urandom);
    bus.fetch_ack = 1'($urandom);
    bus.mem_wait  = 1'($urandom);
  endtask

  // Compare mid-cycle, then advance to just after the next rising edge.
  task automatic tick_check(input string nm, input obs_t e);
    obs_t o;
    @(negedge clk2);
    o = observe();
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, o, e);
    end
    @(posedge clk2);
    #1;
  endtask

  task automatic do_reset();
    scramble();
    reset = 1'b1;
    @(posedge clk2);
    #1;
    reset       = 1'b0;
    model_count = '0;
  endtask

  task automatic idle_cycles(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      scramble();
      bus.start = 1'b0;
      tick_check(nm, quiet());
    end
  endtask

  task automatic start_from_idle(input string nm, input bit with_halt);
    scramble();
    bus.start    = 1'b1;
    bus.halt_req = with_halt;
    tick_check(nm, quiet());
    bus.start    = 1'b0;
    bus.halt_req = 1'b0;
  endtask

  task automatic fault_cycles(input string nm, input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      scramble();
      e       = quiet();
      e.fault = 1'b1;
      tick_check(nm, e);
    end
  endtask

  // Trace model: entered with the sequencer in FETCH, predicts each cycle of one instruction.
  task automatic run_instr(input string nm, input instr_t ins, output end_e res);
    obs_t e;
    int   n;
    bit   last;
    bus.reg_load_1 = ins.ld[0];  bus.select_1 = ins.sel[0];
    bus.reg_load_2 = ins.ld[1];  bus.select_2 = ins.sel[1];
    bus.reg_load_3 = ins.ld[2];  bus.select_3 = ins.sel[2];
    bus.num_of_ope = ins.len;

    for (int k = 0; k <= MAX_WAIT; k++) begin
      if (k == MAX_WAIT) begin
        res = R_FAULT;
        return;
      end
      scramble();
      e           = busy_only();
      e.fetch_req = 1'b1;
      bus.fetch_ack = (k == ins.ack_delay);
      e.ope_latch   = (k == ins.ack_delay);
      tick_check({nm, "_fetch"}, e);
      if (k == ins.ack_delay) break;
    end

    scramble();
    tick_check({nm, "_decode"}, busy_only());

    scramble();
    e = busy_only();
    if (ins.len == 4'h0 || ins.ld[0] == 4'h0) begin
      tick_check({nm, "_advance"}, e);
      res = R_FAULT;
      return;
    end
    e.eip_add_en = 1'b1;
    e.eip_add    = ins.len;
    tick_check({nm, "_advance"}, e);

    n = 1;
    while (n < 3 && ins.ld[n] != 4'h0) n++;
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      for (int w = 0; w <= MAX_WAIT; w++) begin
        if (w == MAX_WAIT) begin
          res = R_FAULT;
          return;
        end
        scramble();
        if (ins.hold_halt) bus.halt_req = 1'b1;
        e            = busy_only();
        e.step_en    = 1'b1;
        e.step_idx   = 2'(i);
        e.alu_load   = ins.ld[i];
        e.alu_select = ins.sel[i];
        if (i == ins.abort_step && w == 0) begin
          reset = 1'b1;
          tick_check({nm, "_step_at_reset"}, e);
          reset       = 1'b0;
          model_count = '0;
          res         = R_IDLE;
          return;
        end
        bus.mem_wait = (w != ins.waits[i]);
        if (w == ins.waits[i] && last) bus.halt_req = ins.halt;
        tick_check({nm, "_step"}, e);
        if (w == ins.waits[i]) break;
      end
      if (last) model_count++;
    end
    bus.halt_req = 1'b0;
    res = ins.halt ? R_IDLE : R_FETCH;
  endtask

  task automatic expect_end(input string nm, input end_e got, input end_e want);
    // The model's own verdict is cross-checked on the next cycle's outputs.
    if (got != want) $display("note: %s ended in unexpected model state", nm);
    if (want == R_IDLE)  idle_cycles({nm, "_after"}, 2);
    if (want == R_FAULT) fault_cycles({nm, "_after"}, 4);
  endtask

  task automatic test_reset();
    do_reset();
    idle_cycles("reset_idle", 3);
  endtask

  task automatic test_push();
    end_e r;
    do_reset();
    start_from_idle("push_start", 1'b0);
    run_instr("push", mk(LD_ESP, LD_ESP, LD_NONE, 4'd1), r);
    if (r != R_FETCH) $display("note: push ended early");
  endtask

  task automatic test_call_wait();
    end_e   r;
    instr_t ins = mk(LD_ESP, LD_ESP, LD_EIP, 4'd5);
    ins.waits[1] = 2;
    run_instr("call", ins, r);
  endtask

  task automatic test_back_to_back();
    end_e   r;
    instr_t ins;
    for (int i = 0; i < 4; i++) begin
      ins = mk(code_t'(i + 1), code_t'(i % 2 == 0 ? 0 : 3), LD_EDI, 4'(i + 2));
      run_instr("b2b", ins, r);
    end
  endtask

  task automatic test_bad_decode();
    end_e r;
    do_reset();
    start_from_idle("badlen_start", 1'b0);
    run_instr("badlen", mk(LD_ESP, LD_ESP, LD_NONE, 4'd0), r);
    expect_end("badlen", r, R_FAULT);
    do_reset();
    idle_cycles("badlen_reset", 1);
    start_from_idle("noload_start", 1'b0);
    run_instr("noload", mk(LD_NONE, LD_ESP, LD_NONE, 4'd3), r);
    expect_end("noload", r, R_FAULT);
  endtask

  task automatic test_watchdog();
    end_e   r;
    instr_t ins;
    do_reset();
    start_from_idle("wd_start", 1'b0);
    ins = mk(LD_EAX, LD_NONE, LD_NONE, 4'd2);
    ins.ack_delay = MAX_WAIT - 1;
    run_instr("ack_late_ok", ins, r);
    ins.ack_delay = MAX_WAIT;
    run_instr("ack_timeout", ins, r);
    expect_end("ack_timeout", r, R_FAULT);
    do_reset();
    start_from_idle("memwait_start", 1'b0);
    ins = mk(LD_EAX, LD_EBP_EBX, LD_NONE, 4'd2);
    ins.waits[1] = MAX_WAIT - 1;
    run_instr("memwait_ok", ins, r);
    ins.waits[1] = MAX_WAIT;
    run_instr("memwait_timeout", ins, r);
    expect_end("memwait_timeout", r, R_FAULT);
  endtask

  task automatic test_halt();
    end_e   r;
    instr_t ins = mk(LD_ESP, LD_EAX, LD_EIP, 4'd3);
    do_reset();
    start_from_idle("start_and_halt", 1'b1);
    run_instr("halt_ignored", mk(LD_EDI, LD_NONE, LD_NONE, 4'd1), r);
    ins.halt      = 1'b1;
    ins.hold_halt = 1'b1;
    run_instr("halt", ins, r);
    expect_end("halt", r, R_IDLE);
  endtask

  task automatic test_reset_mid_step();
    end_e   r;
    instr_t ins = mk(LD_ESP, LD_ESP, LD_EIP, 4'd5);
    do_reset();
    start_from_idle("abort_start", 1'b0);
    run_instr("abort_pre", mk(LD_EAX, LD_NONE, LD_NONE, 4'd1), r);
    ins.abort_step = 1;
    run_instr("abort", ins, r);
    expect_end("abort", r, R_IDLE);
  endtask

  // Enough retires to wrap the narrow retire counter in the bench build.
  task automatic test_random();
    end_e   r = R_IDLE;
    instr_t ins;
    do_reset();
    for (int j = 0; j < 90; j++) begin
      if (r == R_IDLE) begin
        idle_cycles("rnd_idle", $urandom_range(0, 2));
        start_from_idle("rnd_start", 1'($urandom));
      end
      ins = mk(code_t'($urandom_range(1, 6)), code_t'($urandom_range(0, 6)),
               code_t'($urandom_range(0, 6)), 4'($urandom_range(1, 15)));
      ins.ack_delay = $urandom_range(0, 3);
      for (int i = 0; i < 3; i++) ins.waits[i] = $urandom_range(0, 2);
      ins.halt = ($urandom_range(0, 5) == 0);
      run_instr("rnd", ins, r);
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.halt_req   = 1'b0;
    bus.fetch_ack  = 1'b0;
    bus.mem_wait   = 1'b0;
    bus.reg_load_1 = 4'h0;
    bus.reg_load_2 = 4'h0;
    bus.reg_load_3 = 4'h0;
    bus.select_1   = 4'h0;
    bus.select_2   = 4'h0;
    bus.select_3   = 4'h0;
    bus.num_of_ope = 4'h0;
    test_reset();
    test_push();
    test_call_wait();
    test_back_to_back();
    test_bad_decode();
    test_watchdog();
    test_halt();
    test_reset_mid_step();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete within the time limit");
    $fatal(1, "timeout");
  end

endmodule
